// File: rtl/elevator_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module      : elevator_ctrl_n
// Description : N-floor elevator controller. Latches per-floor call pulses,
//               serves them with a SCAN (collective) policy, times travel
//               between floors and door dwell, drives engine code and door.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_ctrl_n #(
  parameter int FLOORS     = 4,
  parameter int FW         = 2,
  parameter int TRAVEL_CYC = 8,
  parameter int DOOR_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] call_req,
  input  logic              door_closed,
  output logic [FW-1:0]     floor,
  output logic [1:0]        engine,
  output logic              door_open_cmd,
  output logic [FLOORS-1:0] pending,
  output logic              dir_up
);

  localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TW-1:0] c_TRAVEL_LOAD = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0] c_DOOR_LOAD   = DW'(DOOR_CYC - 1);
  localparam logic [FW-1:0] c_TOP         = FW'(FLOORS - 1);
  localparam logic [1:0]    c_ENG_STOP    = 2'b00;
  localparam logic [1:0]    c_ENG_UP      = 2'b01;
  localparam logic [1:0]    c_ENG_DOWN    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MOVE_UP    = 3'd1,
    S_MOVE_DOWN  = 3'd2,
    S_DOOR_OPEN  = 3'd3,
    S_DOOR_CLOSE = 3'd4
  } state_t;

  state_t            r_state, w_state_nx, w_dec_state;
  logic [FW-1:0]     r_floor, w_floor_nx, w_floor_up, w_floor_dn;
  logic              r_dir_up, w_dir_up_nx, w_dec_dir;
  logic [FLOORS-1:0] r_pending, w_clear, w_call_mask;
  logic [TW-1:0]     r_travel_cnt, w_travel_nx;
  logic [DW-1:0]     r_door_cnt, w_door_nx;
  logic [FLOORS-1:0] w_here_oh, w_up_oh, w_dn_oh;
  logic              w_here, w_above, w_below, w_beyond_up, w_beyond_dn;
  logic              w_take;

  // Floor-relative views of the latched calls (current, next-up, next-down).
  always_comb begin
    w_floor_up  = r_floor + FW'(1);
    w_floor_dn  = r_floor - FW'(1);
    w_here_oh   = '0;
    w_up_oh     = '0;
    w_dn_oh     = '0;
    w_above     = 1'b0;
    w_below     = 1'b0;
    w_beyond_up = 1'b0;
    w_beyond_dn = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      w_here_oh[i] = (FW'(i) == r_floor);
      w_up_oh[i]   = (FW'(i) == w_floor_up);
      w_dn_oh[i]   = (FW'(i) == w_floor_dn);
      if (r_pending[i]) begin
        if (FW'(i) > r_floor)    w_above     = 1'b1;
        if (FW'(i) < r_floor)    w_below     = 1'b1;
        if (FW'(i) > w_floor_up) w_beyond_up = 1'b1;
        if (FW'(i) < w_floor_dn) w_beyond_dn = 1'b1;
      end
    end
    w_here = |(r_pending & w_here_oh);
  end

  // Stationary decision: serve here first, else keep direction while calls lie ahead, else reverse.
  always_comb begin
    w_dec_state = S_IDLE;
    w_dec_dir   = r_dir_up;
    if (w_here) begin
      w_dec_state = S_DOOR_OPEN;
    end else if (door_closed && (w_above || w_below)) begin
      w_dec_dir   = r_dir_up ? w_above : !w_below;
      w_dec_state = w_dec_dir ? S_MOVE_UP : S_MOVE_DOWN;
    end
  end

  // Next-state, timers, floor and call-clear logic.
  always_comb begin
    w_state_nx  = r_state;
    w_floor_nx  = r_floor;
    w_dir_up_nx = r_dir_up;
    w_travel_nx = r_travel_cnt;
    w_door_nx   = r_door_cnt;
    w_clear     = '0;
    w_call_mask = '1;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE:       w_take = 1'b1;
      S_DOOR_CLOSE: w_take = w_here || door_closed;
      S_MOVE_UP: begin
        // Losing the door interlock (or sitting at the top) stops motion and drops progress.
        if (!door_closed || r_floor == c_TOP) begin
          w_state_nx  = S_IDLE;
          w_travel_nx = '0;
        end else if (r_travel_cnt == '0) begin
          w_floor_nx  = w_floor_up;
          w_travel_nx = c_TRAVEL_LOAD;
          if (|(r_pending & w_up_oh)) begin
            w_state_nx = S_DOOR_OPEN;
            w_clear    = w_up_oh;
            w_door_nx  = c_DOOR_LOAD;
          end else if (!w_beyond_up) begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_travel_nx = r_travel_cnt - TW'(1);
        end
      end
      S_MOVE_DOWN: begin
        if (!door_closed || r_floor == '0) begin
          w_state_nx  = S_IDLE;
          w_travel_nx = '0;
        end else if (r_travel_cnt == '0) begin
          w_floor_nx  = w_floor_dn;
          w_travel_nx = c_TRAVEL_LOAD;
          if (|(r_pending & w_dn_oh)) begin
            w_state_nx = S_DOOR_OPEN;
            w_clear    = w_dn_oh;
            w_door_nx  = c_DOOR_LOAD;
          end else if (!w_beyond_dn) begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_travel_nx = r_travel_cnt - TW'(1);
        end
      end
      S_DOOR_OPEN: begin
        // A repeat call for this floor holds the door instead of being latched.
        w_call_mask = ~w_here_oh;
        if (|(call_req & w_here_oh)) begin
          w_door_nx = c_DOOR_LOAD;
        end else if (r_door_cnt == '0) begin
          w_state_nx = S_DOOR_CLOSE;
        end else begin
          w_door_nx = r_door_cnt - DW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_take) begin
      w_state_nx  = w_dec_state;
      w_dir_up_nx = w_dec_dir;
      case (w_dec_state)
        S_DOOR_OPEN: begin
          w_clear   = w_here_oh;
          w_door_nx = c_DOOR_LOAD;
        end
        S_MOVE_UP, S_MOVE_DOWN: w_travel_nx = c_TRAVEL_LOAD;
        default: ;
      endcase
    end
  end

  // State, position, direction, timers and call latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_floor      <= '0;
      r_dir_up     <= 1'b1;
      r_pending    <= '0;
      r_travel_cnt <= '0;
      r_door_cnt   <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_floor      <= w_floor_nx;
      r_dir_up     <= w_dir_up_nx;
      r_pending    <= (r_pending | (call_req & w_call_mask)) & ~w_clear;
      r_travel_cnt <= w_travel_nx;
      r_door_cnt   <= w_door_nx;
    end
  end

  // Engine code and door command follow the state directly.
  always_comb begin
    engine        = c_ENG_STOP;
    door_open_cmd = (r_state == S_DOOR_OPEN);
    if (r_state == S_MOVE_UP)   engine = c_ENG_UP;
    if (r_state == S_MOVE_DOWN) engine = c_ENG_DOWN;
  end

  assign floor   = r_floor;
  assign pending = r_pending;
  assign dir_up  = r_dir_up;

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_ctrl_n
// Description : Self-checking bench for elevator_ctrl_n (4 floors, 8-cycle
//               travel, 4-cycle door). Directed scenarios plus random calls
//               compared every cycle against a floor/timer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_ctrl_n;

  localparam int FLOORS     = 4;
  localparam int FW         = 2;
  localparam int TRAVEL_CYC = 8;
  localparam int DOOR_CYC   = 4;

  localparam int MD_IDLE    = 0;
  localparam int MD_MOVING  = 1;
  localparam int MD_OPEN    = 2;
  localparam int MD_CLOSING = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLOORS-1:0] call_req;
  logic              door_closed;
  logic [FW-1:0]     floor;
  logic [1:0]        engine;
  logic              door_open_cmd;
  logic [FLOORS-1:0] pending;
  logic              dir_up;

  int checks = 0;
  int errors = 0;

  // reference model
  int              m_mode, m_floor, m_ticks, m_door_left, m_clr;
  bit              m_dir;
  bit [FLOORS-1:0] m_pend;

  bit          ok, done, pulse, prev_door;
  logic [1:0]  prev_eng;
  logic [1:0]  eng_q[$];
  int          stop_q[$];
  bit          dir_q[$];
  int          exp_eng[6]  = '{1, 0, 1, 0, 2, 0};
  int          exp_stop[3] = '{1, 3, 0};
  int          exp_dir[3]  = '{1, 1, 0};

  elevator_ctrl_n #(
    .FLOORS(FLOORS), .FW(FW), .TRAVEL_CYC(TRAVEL_CYC), .DOOR_CYC(DOOR_CYC)
  ) dut (
    .clk(clk), .rst(rst), .call_req(call_req), .door_closed(door_closed),
    .floor(floor), .engine(engine), .door_open_cmd(door_open_cmd),
    .pending(pending), .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standing still: open here, else head toward calls (keep heading if any lie ahead).
  task automatic m_decide(input bit here, input bit above, input bit below);
    if (here) begin
      m_mode      = MD_OPEN;
      m_door_left = DOOR_CYC;
      m_clr       = m_floor;
    end else if (door_closed && (above || below)) begin
      m_dir   = m_dir ? above : !below;
      m_mode  = MD_MOVING;
      m_ticks = TRAVEL_CYC;
    end else begin
      m_mode = MD_IDLE;
    end
  endtask

  task automatic model_step();
    bit here, above, below, beyond;
    bit [FLOORS-1:0] newp;
    if (!rst) begin
      m_mode = MD_IDLE; m_floor = 0; m_dir = 1'b1; m_pend = '0;
      m_ticks = 0; m_door_left = 0;
      return;
    end
    m_clr = -1;
    here  = m_pend[m_floor];
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (m_pend[i] && i > m_floor) above = 1'b1;
      if (m_pend[i] && i < m_floor) below = 1'b1;
    end
    newp = m_pend | call_req;
    case (m_mode)
      MD_IDLE:    m_decide(here, above, below);
      MD_CLOSING: if (here || door_closed) m_decide(here, above, below);
      MD_MOVING: begin
        if (!door_closed) begin
          m_mode = MD_IDLE;
        end else begin
          m_ticks--;
          if (m_ticks == 0) begin
            m_floor = m_dir ? m_floor + 1 : m_floor - 1;
            beyond  = 1'b0;
            for (int i = 0; i < FLOORS; i++)
              if (m_pend[i] && (m_dir ? i > m_floor : i < m_floor)) beyond = 1'b1;
            if (m_pend[m_floor]) begin
              m_mode = MD_OPEN; m_door_left = DOOR_CYC; m_clr = m_floor;
            end else if (!beyond) begin
              m_mode = MD_IDLE;
            end else begin
              m_ticks = TRAVEL_CYC;
            end
          end
        end
      end
      default: begin
        newp[m_floor] = m_pend[m_floor];
        if (call_req[m_floor]) begin
          m_door_left = DOOR_CYC;
        end else begin
          m_door_left--;
          if (m_door_left == 0) m_mode = MD_CLOSING;
        end
      end
    endcase
    if (m_clr >= 0) newp[m_clr] = 1'b0;
    m_pend = newp;
  endtask

  // One clock: advance the model with the applied inputs, then compare after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_floor",   floor,         m_floor);
    chk("m_engine",  engine,        (m_mode == MD_MOVING) ? (m_dir ? 1 : 2) : 0);
    chk("m_door",    door_open_cmd, (m_mode == MD_OPEN) ? 1 : 0);
    chk("m_pending", pending,       m_pend);
    chk("m_dir_up",  dir_up,        m_dir);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; call_req = '0; door_closed = 1'b1;

    // 1: reset values
    do_reset();
    chk("t1_floor", floor, 0);
    chk("t1_engine", engine, 0);
    chk("t1_door", door_open_cmd, 0);
    chk("t1_pending", pending, 0);
    chk("t1_dir_up", dir_up, 1);

    // 2: single call to floor 2, latency and timing
    call_req = 4'b0100; tick(); call_req = '0;
    chk("t2_pending_e0", pending, 4'b0100);
    tick();
    chk("t2_engine_e1", engine, 1);
    repeat (7) tick();
    chk("t2_floor_e8", floor, 0);
    tick();
    chk("t2_floor_e9", floor, 1);
    repeat (8) tick();
    chk("t2_floor_e17", floor, 2);
    chk("t2_engine_e17", engine, 0);
    chk("t2_door_e17", door_open_cmd, 1);
    chk("t2_pending_e17", pending, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_door_hold", door_open_cmd, 1);
    end
    tick();
    chk("t2_door_e21", door_open_cmd, 0);
    tick();
    chk("t2_engine_e22", engine, 0);

    // 3: SCAN ordering of stops 1, 3, 0
    do_reset();
    call_req = 4'b1000; tick(); call_req = '0;
    tick(); tick();
    call_req = 4'b0010; tick(); call_req = '0;
    prev_eng = 2'b00; prev_door = 1'b0; pulse = 1'b0; done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (engine != prev_eng) begin eng_q.push_back(engine); prev_eng = engine; end
      if (door_open_cmd && !prev_door) begin
        stop_q.push_back(int'(floor)); dir_q.push_back(dir_up);
        if (floor == 2'd1) pulse = 1'b1;
      end
      prev_door = door_open_cmd;
      if (stop_q.size() == 3 && !door_open_cmd) done = 1'b1;
      else begin
        call_req = pulse ? 4'b0001 : 4'b0000;
        pulse = 1'b0;
        tick();
        call_req = '0;
      end
    end
    chk("t3_done", done, 1);
    chk("t3_eng_len", eng_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("t3_eng_seq", (i < eng_q.size()) ? 32'(eng_q[i]) : 32'hFFFF_FFFF, exp_eng[i]);
    for (int i = 0; i < 3; i++) begin
      chk("t3_stop_seq", (i < stop_q.size()) ? stop_q[i] : -1, exp_stop[i]);
      chk("t3_dir_seq", (i < dir_q.size()) ? 32'(dir_q[i]) : 32'hFFFF_FFFF, exp_dir[i]);
    end

    // 4: door interlock
    do_reset();
    door_closed = 1'b0;
    call_req = 4'b0100; tick(); call_req = '0;
    repeat (3) tick();
    chk("t4_engine_held", engine, 0);
    chk("t4_pending", pending, 4'b0100);
    door_closed = 1'b1; tick();
    chk("t4_engine_go", engine, 1);
    repeat (3) tick();
    door_closed = 1'b0; tick();
    chk("t4_engine_stop", engine, 0);
    chk("t4_floor_held", floor, 0);
    repeat (2) tick();
    chk("t4_engine_still", engine, 0);
    door_closed = 1'b1; tick();
    chk("t4_engine_resume", engine, 1);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin tick(); ok = door_open_cmd; end
    chk("t4_arrive", ok, 1);
    chk("t4_floor2", floor, 2);

    // 5: current-floor call first, door-hold on repeat call
    do_reset();
    call_req = 4'b0011; tick(); call_req = '0;
    chk("t5_pending_e0", pending, 4'b0011);
    tick();
    chk("t5_door_e1", door_open_cmd, 1);
    chk("t5_pending_e1", pending, 4'b0010);
    tick();
    call_req = 4'b0001; tick(); call_req = '0;
    chk("t5_pending_e3", pending, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_door_ext", door_open_cmd, 1);
    end
    tick();
    chk("t5_door_e7", door_open_cmd, 0);
    tick();
    chk("t5_engine_e8", engine, 1);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin tick(); ok = door_open_cmd; end
    chk("t5_arrive", ok, 1);
    chk("t5_floor1", floor, 1);

    // 6: reset while travelling down
    call_req = 4'b1000; tick(); call_req = '0;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin tick(); ok = (floor == 2'd3) && door_open_cmd; end
    chk("t6_reach3", ok, 1);
    call_req = 4'b0001; tick(); call_req = '0;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin tick(); ok = (floor == 2'd2) && (engine == 2'b10); end
    chk("t6_reach2_down", ok, 1);
    chk("t6_pending", pending, 4'b0001);
    do_reset();
    chk("t6_floor", floor, 0);
    chk("t6_engine", engine, 0);
    chk("t6_door", door_open_cmd, 0);
    chk("t6_pending_rst", pending, 0);
    chk("t6_dir_up", dir_up, 1);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      call_req    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      door_closed = ($urandom_range(0, 24) != 0);
      rst         = ($urandom_range(0, 799) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
